// File: rtl/fen_pkg.sv
// Shared types and constants for the two-requester FEN stream arbiter.
package fen_pkg;
  localparam int NUM_REQ = 2;
  localparam int FEN_W   = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_PKT, ST_DRAIN} arb_state_t;

  // Adds up to two dropped beats to an 8-bit counter, sticking at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/fen_stream_arb_if.sv
// Requester-side and decoder-side signals of the FEN stream arbiter.
interface fen_stream_arb_if;
  import fen_pkg::*;

  logic [FEN_W-1:0]   req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_sop;
  logic [NUM_REQ-1:0] req_eop;
  logic [NUM_REQ-1:0] req_ready;
  logic               dec_busy;
  logic [FEN_W-1:0]   out_data;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic [NUM_REQ-1:0] grant;
  logic               o_abort;
  logic [7:0]         drop_count;

  modport master (
    output req_data, req_valid, req_sop, req_eop, dec_busy,
    input  req_ready, out_data, out_valid, out_sop, out_eop, grant, o_abort, drop_count
  );

  modport slave (
    input  req_data, req_valid, req_sop, req_eop, dec_busy,
    output req_ready, out_data, out_valid, out_sop, out_eop, grant, o_abort, drop_count
  );
endinterface

// File: rtl/fen_stream_arb_rr.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  // prio_reg=0 favours requester 0, 1 favours requester 1
  logic prio_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      prio_reg <= gnt[0];
    end
  end
endmodule

// File: rtl/fen_stream_arb.sv
// Shares one FEN decoder between two byte-stream requesters, one whole packet at a time.
module fen_stream_arb
  import fen_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int DRAIN_MIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  fen_stream_arb_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int DW = (DRAIN_MIN > 1) ? $clog2(DRAIN_MIN) : 1;

  arb_state_t         state_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [CW-1:0]      idle_cnt_reg;
  logic [DW-1:0]      drain_cnt_reg;
  logic [FEN_W-1:0]   out_data_reg;
  logic               out_valid_reg, out_sop_reg, out_eop_reg;
  logic               abort_reg;
  logic [7:0]         drop_reg;

  logic [NUM_REQ-1:0] sop_req, stray, ready, accept, arb_gnt;
  logic [1:0]         n_stray;
  logic               advance, pkt_beat;
  logic [FEN_W-1:0]   sel_data;
  logic               sel_sop, sel_eop;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign sop_req[gi] = bus.req_valid[gi] & bus.req_sop[gi];
      // Stray (non-sop) beats are swallowed while idle so they cannot wedge a requester.
      assign stray[gi]   = (state_reg == ST_IDLE) & bus.req_valid[gi] & ~bus.req_sop[gi];
      assign ready[gi]   = ~reset & (stray[gi] | ((state_reg == ST_PKT) & grant_reg[gi]));
      assign accept[gi]  = ready[gi] & bus.req_valid[gi];
    end
  endgenerate

  assign n_stray  = {1'b0, stray[0]} + {1'b0, stray[1]};
  assign advance  = (state_reg == ST_IDLE) & (|sop_req) & ~bus.dec_busy;
  assign pkt_beat = (state_reg == ST_PKT) & (|accept);
  assign sel_data = bus.req_data[grant_reg[1]];
  assign sel_sop  = bus.req_sop[grant_reg[1]];
  assign sel_eop  = bus.req_eop[grant_reg[1]];

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (sop_req),
    .advance (advance),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= '0;
      idle_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      drop_reg      <= '0;
    end else begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          drop_reg <= sat_add8(drop_reg, n_stray);
          if (advance) begin
            state_reg    <= ST_PKT;
            grant_reg    <= arb_gnt;
            idle_cnt_reg <= '0;
          end
        end
        ST_PKT: begin
          if (pkt_beat) begin
            out_data_reg  <= sel_data;
            out_valid_reg <= 1'b1;
            out_sop_reg   <= sel_sop;
            out_eop_reg   <= sel_eop;
            idle_cnt_reg  <= '0;
            if (sel_eop) begin
              state_reg     <= ST_DRAIN;
              grant_reg     <= '0;
              drain_cnt_reg <= '0;
            end
          end else if (idle_cnt_reg == CW'(TIMEOUT - 1)) begin
            // Abandoned packet: no eop is made up for the decoder.
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            abort_reg    <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == DW'(DRAIN_MIN - 1)) begin
            if (!bus.dec_busy) begin
              state_reg <= ST_IDLE;
            end
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.out_data   = out_data_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_sop    = out_sop_reg;
  assign bus.out_eop    = out_eop_reg;
  assign bus.grant      = grant_reg;
  assign bus.o_abort    = abort_reg;
  assign bus.drop_count = drop_reg;
endmodule

// File: doc/fen_stream_arb.md
FEN_STREAM_ARB -- requirements
Module: fen_stream_arb

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 255, idle cycles allowed mid-packet before abort; DRAIN_MIN, default 2, minimum cycles spent in DRAIN.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_data[i]  in  8  ASCII byte from requester i (i=0,1).
- req_valid[i], req_sop[i], req_eop[i]  in  1 each  beat qualifiers from requester i.
- req_ready[i]  out  1  beat from requester i accepted this cycle.
- dec_busy  in  1  decoder is emitting a decoded board (not accepting a new FEN).
- out_data  out  8  byte to the FEN decoder.
- out_valid, out_sop, out_eop  out  1 each  qualifiers to the FEN decoder.
- grant  out  2  one-hot owner of the current packet; 0 when there is no owner.
- o_abort  out  1  one-cycle pulse on timeout abort.
- drop_count  out  8  saturating count of discarded stray beats.

Function
REQ-003 The block SHALL share one FEN decoder between two byte-stream requesters at whole-packet granularity (sop..eop); packets SHALL never interleave.
REQ-004 States: IDLE, PKT, DRAIN.
REQ-005 IDLE -> PKT when any requester presents valid&sop and dec_busy=0.
- Winner is chosen round-robin: the requester not granted last wins a tie.
- After reset the pointer favours requester 0.
- grant updates on the transition.
REQ-006 In IDLE, any beat with valid=1 and sop=0 SHALL be accepted (ready=1), discarded, and drop_count incremented, saturating at 255.
- Both requesters dropping in the same cycle SHALL count +2, still saturating.
REQ-007 In IDLE, a valid&sop beat SHALL NOT be accepted (ready=0); it is accepted in PKT on the following cycle.
REQ-008 In PKT, req_ready SHALL equal 1 for the granted requester and 0 for the other.
- The ready signal is combinational from the state and grant only; it is not a function of req_valid.
REQ-009 Each accepted beat in PKT SHALL appear on out_* exactly one cycle later with data, sop and eop unchanged; out_valid=0 otherwise.
REQ-010 An accepted beat with eop=1 SHALL move the state PKT -> DRAIN and clear grant the same cycle the state changes.
REQ-011 A second sop from the granted requester inside PKT SHALL be forwarded unchanged and the state SHALL stay PKT, because the decoder restarts on sop.
REQ-012 DRAIN SHALL last at least DRAIN_MIN cycles, then -> IDLE on the first cycle with dec_busy=0.
- Requesters see ready=0 throughout DRAIN.
REQ-013 PKT SHALL use an idle counter:
- It resets on every accepted beat.
- If TIMEOUT consecutive cycles pass with no valid beat from the granted requester, the state goes -> IDLE, o_abort pulses for 1 cycle, and grant clears.
- No out_eop is synthesised on abort.
REQ-014 A beat carrying both sop and eop SHALL be a complete one-beat packet: forwarded, then -> DRAIN.
REQ-015 The round-robin pointer SHALL update only on an IDLE -> PKT grant, not on abort or drop.

Reset
REQ-016 While reset=1 on a clock edge, the block SHALL go to IDLE and hold:
- grant=0, req_ready=0, out_valid=out_sop=out_eop=0, out_data=0;
- o_abort=0, drop_count=0, idle counter=0;
- round-robin pointer favouring requester 0.
REQ-017 Reset mid-packet SHALL abandon the packet with no eop emitted; the first cycle after reset behaves as IDLE.

Structure
REQ-018 A shared package fen_pkg SHALL hold the state enumeration, the requester count constant (2) and the FEN byte width (8).
REQ-019 Round-robin selection SHALL be a sub-module rr_arbiter2 with inputs req[1:0] and advance, and output one-hot gnt[1:0]; the pointer is internal to the sub-module.

Verification
REQ-020 Single packet: requester 0 sends "8/8/8/8/8/8/8/8 w - - 0 1" with sop on the first byte and eop on the last.
- out_* reproduces all 25 bytes, each 1 cycle delayed.
- grant=01 during the packet, then DRAIN for >=2 cycles, then IDLE.
REQ-021 Contention: both requesters assert valid&sop in the same cycle after reset.
- Requester 0 is served first, requester 1 second.
- On the next simultaneous contention, requester 0 wins again; no bytes interleave.
REQ-022 Busy gating: dec_busy=1 held for 10 cycles while requester 1 waits with sop.
- No grant is issued; grant rises on the first cycle after dec_busy falls.
- dec_busy=1 arriving during DRAIN holds DRAIN until it falls.
REQ-023 Stray beats: requester 1 sends 3 beats without sop in IDLE -> drop_count=3 and out_valid stays 0; 300 such beats -> drop_count=255.
REQ-024 Timeout: with TIMEOUT=4, requester 0 sends sop plus 2 bytes and then stalls.
- o_abort pulses on the 4th idle cycle; the state returns to IDLE.
- A new packet from requester 1 is then granted normally.
REQ-025 Reset mid-packet: assert reset after the 5th forwarded byte.
- All outputs are 0 the cycle after the reset edge.
- The next sop from requester 1 is granted with grant=10.
